vector_mem_unit: RTL and testbench
==================================

Name: vector_mem_unit

Overview:
- Multi-beat vector load/store engine between the 32-bit data memory port and the 256-bit vector register file.
- Load: fetches NUM_WORDS consecutive 32-bit words, assembles one vector, and drives the register file write port (WE3/A3/WD3).
- Store: takes a vector read from the register file (RD2) and writes it to memory as NUM_WORDS consecutive words.
- Sits directly upstream of the register file write port and downstream of its read port.

Parameters:
- REG_WIDTH, 256, vector register width in bits.
- WORD_WIDTH, 32, memory word and lane width in bits.
- ADDR_WIDTH, 32, byte address width.
- NUM_WORDS, REG_WIDTH/WORD_WIDTH (8), beats per transfer; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only when busy=0.
- op  in  1  0=load, 1=store; captured with start.
- base_addr  in  ADDR_WIDTH  byte address of lane 0; captured with start.
- rd_addr  in  5  destination register for load; captured with start.
- store_data  in  REG_WIDTH  vector to store (from RD2); captured with start.
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 for store beats, 0 for load beats.
- mem_addr  out  ADDR_WIDTH  beat byte address.
- mem_wdata  out  WORD_WIDTH  store beat data.
- mem_rdata  in  WORD_WIDTH  load beat data; valid when mem_ready=1.
- mem_ready  in  1  beat completes at posedge where mem_req=1 and mem_ready=1.
- rf_we  out  1  register file write enable (to WE3).
- rf_waddr  out  5  register file write address (to A3).
- rf_wdata  out  REG_WIDTH  register file write data (to WD3).

Behaviour:
- FSM states: IDLE, XFER, WRITEBACK, DONE. 3-bit beat counter. Captured base, op, rd, and a REG_WIDTH buffer.
- Reset (rst_n=0, async): state=IDLE, counter=0, buffer=0. All outputs 0: busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr, rf_wdata.
- IDLE:
  - start=1 captures op, rd_addr, base_addr with bits [1:0] forced to 0, and store_data into buffer if op=1.
  - Clears the buffer if op=0.
  - Moves to XFER.
- XFER:
  - mem_req=1; mem_we=op.
  - mem_addr = base + 4*k, modulo 2^ADDR_WIDTH (wrap-around permitted).
  - mem_wdata = buffer lane k, where lane k = bits [WORD_WIDTH*k+WORD_WIDTH-1 : WORD_WIDTH*k] (lane 0 is LSBs).
  - Outputs are held stable while mem_ready=0; unlimited wait states.
  - On a completed load beat, mem_rdata is written into buffer lane k.
  - k increments on each completed beat. After beat NUM_WORDS-1 completes: load -> WRITEBACK, store -> DONE.
- WRITEBACK (one cycle): rf_we=1, rf_waddr=captured rd, rf_wdata=buffer, done=1, mem_req=0. Next state IDLE.
- DONE (one cycle, store only): done=1, rf_we=0. Next state IDLE.
- rf_we is never asserted for stores. rf_wdata and rf_waddr are 0 whenever rf_we=0.
- Register 0 receives no special treatment; it is written like any other register.
- busy=1 in XFER, WRITEBACK and DONE. start while busy=1 is ignored: no queuing, no captured change.
- start in the WRITEBACK/DONE cycle is ignored. Earliest accepted restart is the cycle after done.
- mem_ready while mem_req=0 is ignored.
- Latency with mem_ready tied high:
  - start accepted at edge 0; beats complete at edges 1..8.
  - done/rf_we high in the cycle following edge 8, i.e. NUM_WORDS+1 cycles after acceptance.
- Reset mid-transfer aborts immediately. The partial load buffer is discarded and rf_we does not fire. No done pulse.
- mem_rdata is captured only on completed beats. Stale data during wait states must not corrupt the buffer.

Test Plan:
- Load, mem_ready=1, base=0x100, memory word at 0x100+4k = k+1, rd_addr=5 -> 8 beats at 0x100..0x11C, one rf_we pulse with rf_waddr=5, rf_wdata=256'h00000008_00000007_..._00000001, done coincident with rf_we, busy low the next cycle.
- Store, store_data=256'hFEAFEAFE repeated, base=0x200, mem_ready toggling 1-of-3 -> 8 writes mem_we=1 with data 0xFEAFEAFE at 0x200..0x21C, mem_addr/mem_wdata stable during stalls, done once, rf_we never high.
- Misalignment and wrap, base=0xFFFFFFF3 load -> addresses 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000..0x0000000C.
- start held high through a load -> exactly one transfer per acceptance. A second transfer begins only after busy falls, and its captured rd_addr is the value present on that later start cycle.
- rst_n low after beat 4 of a load -> all outputs 0 asynchronously, no rf_we, no done. A new load after release returns fresh data with no residue from the aborted buffer.
- Back-to-back load to rd=7 then store of RD2 -> correct rf_we for the load, correct 8 store beats, total cycles = 2*(NUM_WORDS+1)+1 with mem_ready=1.

Source files
------------

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: multi-beat vector load/store engine between a 32-bit data
// memory port and a 256-bit vector register file.
//   Load : NUM_WORDS word reads assembled into one vector, then a single
//          register file write (rf_we/rf_waddr/rf_wdata).
//   Store: a captured vector written out as NUM_WORDS consecutive words.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   start, op, base_addr, rd_addr,    request and its payload (sampled when idle)
//   store_data
//   busy, done                        status / one-cycle completion pulse
//   mem_req, mem_we, mem_addr,        memory beat request
//   mem_wdata, mem_rdata, mem_ready
//   rf_we, rf_waddr, rf_wdata         register file write port
// All outputs are registered.
module vector_mem_unit #(
    parameter int unsigned REG_WIDTH  = 256,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [4:0]            rd_addr,
    input  logic [REG_WIDTH-1:0]  store_data,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [REG_WIDTH-1:0]  rf_wdata
);

    localparam int unsigned NUM_WORDS = REG_WIDTH / WORD_WIDTH;
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned RD_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_XFER      = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic                  r_op, w_op_next;
    logic [ADDR_WIDTH-1:0] r_base, w_base_next;
    logic [RD_W-1:0]       r_rd, w_rd_next;
    logic [REG_WIDTH-1:0]  r_buf, w_buf_next;
    logic                  w_beat, w_last_beat;

    logic                  r_busy, r_done, r_mem_req, r_mem_we, r_rf_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0] r_mem_wdata;
    logic [RD_W-1:0]       r_rf_waddr;
    logic [REG_WIDTH-1:0]  r_rf_wdata;

    logic                  w_busy_next, w_done_next, w_mem_req_next, w_mem_we_next, w_rf_we_next;
    logic [ADDR_WIDTH-1:0] w_mem_addr_next;
    logic [WORD_WIDTH-1:0] w_mem_wdata_next;
    logic [RD_W-1:0]       w_rf_waddr_next;
    logic [REG_WIDTH-1:0]  w_rf_wdata_next;

    // mem_req is high exactly in XFER, so a handshake is XFER plus ready
    assign w_beat      = (r_state == ST_XFER) && mem_ready;
    assign w_last_beat = w_beat && (r_cnt == CNT_W'(NUM_WORDS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_state_next = ST_XFER;
            ST_XFER:      if (w_last_beat) w_state_next = r_op ? ST_DONE : ST_WRITEBACK;
            ST_WRITEBACK: w_state_next = ST_IDLE;
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // Request capture, beat counter and lane assembly
    always_comb begin
        w_cnt_next  = r_cnt;
        w_op_next   = r_op;
        w_base_next = r_base;
        w_rd_next   = r_rd;
        w_buf_next  = r_buf;
        if ((r_state == ST_IDLE) && start) begin
            w_op_next   = op;
            w_rd_next   = rd_addr;
            w_base_next = base_addr & ~ADDR_WIDTH'(3);
            w_buf_next  = op ? store_data : '0;
            w_cnt_next  = '0;
        end else if (w_beat) begin
            // rdata only lands on a completed beat; stall-cycle data is dropped
            if (!r_op) begin
                w_buf_next[WORD_WIDTH*32'(r_cnt) +: WORD_WIDTH] = mem_rdata;
            end
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_op   <= 1'b0;
            r_base <= '0;
            r_rd   <= '0;
            r_buf  <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_op   <= w_op_next;
            r_base <= w_base_next;
            r_rd   <= w_rd_next;
            r_buf  <= w_buf_next;
        end
    end

    // Output decode from next state so every output leaves a flop
    always_comb begin
        w_busy_next      = (w_state_next != ST_IDLE);
        w_mem_req_next   = (w_state_next == ST_XFER);
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = '0;
        w_mem_wdata_next = '0;
        w_done_next      = (w_state_next == ST_WRITEBACK) || (w_state_next == ST_DONE);
        w_rf_we_next     = (w_state_next == ST_WRITEBACK);
        w_rf_waddr_next  = '0;
        w_rf_wdata_next  = '0;
        if (w_mem_req_next) begin
            w_mem_we_next    = w_op_next;
            // address wraps modulo 2^ADDR_WIDTH
            w_mem_addr_next  = w_base_next + (ADDR_WIDTH'(w_cnt_next) << 2);
            w_mem_wdata_next = w_buf_next[WORD_WIDTH*32'(w_cnt_next) +: WORD_WIDTH];
        end
        if (w_rf_we_next) begin
            w_rf_waddr_next = w_rd_next;
            w_rf_wdata_next = w_buf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
        end else begin
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_rf_we     <= w_rf_we_next;
            r_rf_waddr  <= w_rf_waddr_next;
            r_rf_wdata  <= w_rf_wdata_next;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Bench for vector_mem_unit: directed transfers, a transfer-level model and
// per-cycle comparison of every DUT output against it.
module tb_vector_mem_unit;

    logic         clk, rst_n, start, op;
    logic [31:0]  base_addr;
    logic [4:0]   rd_addr;
    logic [255:0] store_data;
    logic         busy, done, mem_req, mem_we, mem_ready, rf_we;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [4:0]   rf_waddr;
    logic [255:0] rf_wdata;

    vector_mem_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .base_addr(base_addr), .rd_addr(rd_addr), .store_data(store_data),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input logic [255:0] v, input int k);
        return v[k*32 +: 32];
    endfunction

    // Sparse word memory; unwritten words read as an address-derived pattern
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Transfer-level model: one outstanding request, 8 beats, then a done cycle
    logic         m_active = 1'b0, m_finish = 1'b0, m_op = 1'b0;
    int           m_k = 0;
    logic [4:0]   m_rd = '0;
    logic [31:0]  m_base = '0;
    logic [255:0] m_vec = '0;
    int           mem_mode = 0;
    int           stall = 0;
    int           n_done = 0, acc_cyc = 0, done_cyc = 0;
    int           rf_cnt = 0, done_cnt = 0;
    logic [4:0]   rf_log[$];
    logic [31:0]  beat_log[$];
    logic [255:0] last_rf = '0;

    // Compare + memory responder; inputs are driven #1 after posedge, so
    // everything the next posedge will see is stable here
    always @(negedge clk) begin : mon
        logic        mbusy, rdy;
        logic [31:0] ea, w;
        if (!rst_n) begin
            chk("rst_busy", 256'(busy), 256'(0));
            chk("rst_done", 256'(done), 256'(0));
            chk("rst_req", 256'(mem_req), 256'(0));
            chk("rst_rfwe", 256'(rf_we), 256'(0));
            chk("rst_addr", 256'(mem_addr), 256'(0));
            chk("rst_rfdata", rf_wdata, 256'(0));
            m_active = 1'b0; m_finish = 1'b0; m_k = 0;
            mem_ready = 1'b1;
        end else begin
            if (rf_we) begin rf_cnt++; rf_log.push_back(rf_waddr); last_rf = rf_wdata; end
            if (done) done_cnt++;
            mbusy = m_active || m_finish;
            mem_ready = 1'b1;
            mem_rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
            if (m_finish) begin
                chk("fin_busy", 256'(busy), 256'(1));
                chk("fin_done", 256'(done), 256'(1));
                chk("fin_req", 256'(mem_req), 256'(0));
                chk("fin_rfwe", 256'(rf_we), 256'(!m_op));
                chk("fin_waddr", 256'(rf_waddr), m_op ? 256'(0) : 256'(m_rd));
                chk("fin_wdata", rf_wdata, m_op ? 256'(0) : m_vec);
                m_finish = 1'b0;
                n_done++;
                done_cyc = cyc;
            end else if (m_active) begin
                ea = m_base + 32'(4 * m_k);
                chk("x_busy", 256'(busy), 256'(1));
                chk("x_done", 256'(done), 256'(0));
                chk("x_req", 256'(mem_req), 256'(1));
                chk("x_rfwe", 256'(rf_we), 256'(0));
                chk("x_we", 256'(mem_we), 256'(m_op));
                chk("x_addr", 256'(mem_addr), 256'(ea));
                chk("x_wdata", 256'(mem_wdata), 256'(lane(m_vec, m_k)));
                rdy = (mem_mode == 0) || (stall == 2);
                stall = (stall + 1) % 3;
                mem_ready = rdy;
                if (rdy) begin
                    beat_log.push_back(mem_addr);
                    if (m_op) begin
                        mem[mem_addr] = mem_wdata;
                    end else begin
                        w = memrd(ea);
                        mem_rdata = w;
                        m_vec[m_k*32 +: 32] = w;
                    end
                    m_k++;
                    if (m_k == 8) begin m_active = 1'b0; m_finish = 1'b1; end
                end
            end else begin
                chk("i_busy", 256'(busy), 256'(0));
                chk("i_done", 256'(done), 256'(0));
                chk("i_req", 256'(mem_req), 256'(0));
                chk("i_rfwe", 256'(rf_we), 256'(0));
                chk("i_waddr", 256'(rf_waddr), 256'(0));
                chk("i_wdata", rf_wdata, 256'(0));
            end
            if (start && !mbusy) begin
                m_active = 1'b1; m_op = op; m_rd = rd_addr;
                m_base = base_addr & ~32'd3;
                m_vec = op ? store_data : '0;
                m_k = 0; stall = 0;
                acc_cyc = cyc + 1;
            end
        end
    end

    task automatic issue(input logic o, input logic [31:0] b, input logic [4:0] rd, input logic [255:0] sd);
        @(posedge clk); #1;
        start = 1'b1; op = o; base_addr = b; rd_addr = rd; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0 = n_done;
        int i = 0;
        while (n_done == n0 && i < budget) begin @(posedge clk); i++; end
        total++;
        if (n_done == n0) begin bad++; $display("FAIL timeout: no completion within %0d cycles", budget); end
    endtask

    logic [255:0] feafe, exp1, exp5;
    int t0, snap_rf, snap_done, i;

    initial begin
        rst_n = 1'b1; start = 1'b0; op = 1'b0; base_addr = '0; rd_addr = '0;
        store_data = '0; mem_ready = 1'b1; mem_rdata = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_req", 256'(mem_req), 256'(0));
        chk("reset_rfwe", 256'(rf_we), 256'(0));
        chk("reset_wdata", rf_wdata, 256'(0));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Load with ready tied high
        for (int k = 0; k < 8; k++) mem[32'h100 + 32'(4*k)] = 32'(k + 1);
        issue(1'b0, 32'h100, 5'd5, '0);
        wait_done(50);
        #1 chk("t1_busy_low", 256'(busy), 256'(0));
        exp1 = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
        chk("t1_rfdata", last_rf, exp1);
        chk("t1_waddr", 256'(rf_log[$]), 256'(5));
        chk("t1_latency", 256'(done_cyc + 1 - acc_cyc), 256'(9));

        // Store with 1-of-3 ready
        feafe = {8{32'hFEAFEAFE}};
        snap_rf = rf_cnt;
        mem_mode = 1;
        issue(1'b1, 32'h200, 5'd0, feafe);
        wait_done(100);
        mem_mode = 0;
        chk("t2_mem200", 256'(memrd(32'h200)), 256'(32'hFEAFEAFE));
        chk("t2_mem21c", 256'(memrd(32'h21C)), 256'(32'hFEAFEAFE));
        chk("t2_no_rfwe", 256'(rf_cnt), 256'(snap_rf));

        // Misaligned base wrapping past 2^32
        beat_log.delete();
        issue(1'b0, 32'hFFFF_FFF3, 5'd9, '0);
        wait_done(50);
        chk("t3_nbeats", 256'(beat_log.size()), 256'(8));
        if (beat_log.size() == 8) begin
            chk("t3_a0", 256'(beat_log[0]), 256'(32'hFFFF_FFF0));
            chk("t3_a3", 256'(beat_log[3]), 256'(32'hFFFF_FFFC));
            chk("t3_a4", 256'(beat_log[4]), 256'(32'h0000_0000));
            chk("t3_a7", 256'(beat_log[7]), 256'(32'h0000_000C));
        end

        // start held high: one transfer per acceptance, rd sampled at accept
        snap_done = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; base_addr = 32'h400; rd_addr = 5'd3;
        @(posedge clk); #1;
        rd_addr = 5'd9;
        wait_done(50);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50);
        repeat (5) @(posedge clk);
        chk("t4_ndone", 256'(done_cnt - snap_done), 256'(2));
        chk("t4_rd_first", 256'(rf_log[$-1]), 256'(3));
        chk("t4_rd_second", 256'(rf_log[$]), 256'(9));

        // Reset after four load beats
        issue(1'b0, 32'h500, 5'd4, '0);
        i = 0;
        while (m_k < 4 && i < 50) begin @(negedge clk); i++; end
        chk("t5_reached4", 256'(m_k), 256'(4));
        @(posedge clk); #2;
        rst_n = 1'b0;
        snap_rf = rf_cnt; snap_done = done_cnt;
        #1;
        chk("t5_busy", 256'(busy), 256'(0));
        chk("t5_req", 256'(mem_req), 256'(0));
        chk("t5_addr", 256'(mem_addr), 256'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("t5_no_rfwe", 256'(rf_cnt), 256'(snap_rf));
        chk("t5_no_done", 256'(done_cnt), 256'(snap_done));
        for (int k = 0; k < 8; k++) mem[32'h600 + 32'(4*k)] = 32'h1111_0000 + 32'(k);
        issue(1'b0, 32'h600, 5'd12, '0);
        wait_done(50);
        exp5 = 256'h11110007_11110006_11110005_11110004_11110003_11110002_11110001_11110000;
        chk("t5_fresh", last_rf, exp5);
        chk("t5_waddr", 256'(rf_log[$]), 256'(12));

        // Back-to-back load then store with start held
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; base_addr = 32'h700; rd_addr = 5'd7;
        wait_done(50);
        t0 = acc_cyc;
        #1;
        op = 1'b1; base_addr = 32'h800; store_data = exp5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50);
        chk("t6_rd", 256'(rf_log[$]), 256'(7));
        chk("t6_cycles", 256'(done_cyc + 1 - t0), 256'(19));
        chk("t6_mem81c", 256'(memrd(32'h81C)), 256'(32'h1111_0007));

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
